// File: rtl/tile_packet_generator.sv
// ---------------------------------------------------------------------------
// tile_packet_generator
//
// Upstream feeder for the per-pixel solver stage. A tile job is loaded over a
// typed 32-bit config stream. The block then walks every pixel of a
// 2^TILE_BITS x 2^TILE_BITS tile in raster order (x fastest). For each pixel
// it emits one typed packet on a valid/ready stream:
//   address word, limb-count word, N real limbs, N imaginary limbs, and an
//   iteration-limit word flagged with out_end_of_stream.
// Between pixels the complex coordinate is advanced by a limb-serial
// multi-precision add, least significant limb first.
//
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   cfg_data/valid     : typed config word ([31:29] type, [28:0] payload)
//   cfg_ready          : high only while idle and waiting for a job
//   cfg_last           : final word of a job; starts the tile walk
//   out_data/valid     : typed packet word towards the solver stage
//   out_ready          : downstream accepts the current word
//   out_end_of_stream  : marks the last word of each pixel packet
//   tile_done          : one-cycle pulse after the final packet is accepted
// ---------------------------------------------------------------------------
module tile_packet_generator #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 27,
    parameter int TILE_BITS       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_last,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_end_of_stream,
    output logic        tile_done
);

    localparam int DEPTH = 2 ** LIMB_INDEX_BITS;

    // The packet word being presented is encoded directly in the state so
    // that each EMIT sub-phase is explicit; ADV_X/ADV_Y run the limb adder.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LIMBS,
        S_REAL,
        S_IMAG,
        S_ITER,
        S_ADV_X,
        S_ADV_Y
    } state_t;

    state_t state;
    state_t state_next;

    // Limb storage, limb 0 is the most significant.
    logic [LIMB_SIZE_BITS-1:0] start_real [DEPTH];
    logic [LIMB_SIZE_BITS-1:0] cur_real   [DEPTH];
    logic [LIMB_SIZE_BITS-1:0] cur_imag   [DEPTH];
    logic [LIMB_SIZE_BITS-1:0] step_mem   [DEPTH];

    logic [28:0]                base_addr;
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [15:0]                iter_lim;
    logic [LIMB_INDEX_BITS-1:0] real_wr_idx;
    logic [LIMB_INDEX_BITS-1:0] imag_wr_idx;
    logic [LIMB_INDEX_BITS-1:0] step_wr_idx;
    logic [TILE_BITS-1:0]       x;
    logic [TILE_BITS-1:0]       y;
    logic [LIMB_INDEX_BITS-1:0] limb_k;
    logic                       carry;
    logic                       tile_done_q;

    logic                       cfg_fire;
    logic                       out_fire;
    logic [2:0]                 cfg_type;
    logic [LIMB_SIZE_BITS-1:0]  cfg_limb;
    logic [LIMB_INDEX_BITS-1:0] last_limb_idx;
    logic                       last_limb;
    logic                       last_x;
    logic                       last_y;
    logic [28:0]                pixel_addr;
    logic [LIMB_SIZE_BITS-1:0]  adv_operand;
    logic [LIMB_SIZE_BITS:0]    adv_sum;

    assign cfg_fire      = cfg_valid && cfg_ready;
    assign out_fire      = out_valid && out_ready;
    assign cfg_type      = cfg_data[31:29];
    assign cfg_limb      = cfg_data[LIMB_SIZE_BITS-1:0];
    assign last_limb_idx = num_limbs - LIMB_INDEX_BITS'(1);
    assign last_limb     = (limb_k == last_limb_idx);
    assign last_x        = &x;
    assign last_y        = &y;

    // y*2^TILE_BITS + x is just the concatenation {y, x}; the sum wraps at 29 bits.
    assign pixel_addr = base_addr + 29'({y, x});

    // One limb of the serial adder: ADV_X advances the real part, ADV_Y the
    // imaginary part. The carry out of limb 0 is simply dropped on the final
    // cycle, giving two's-complement wrap.
    assign adv_operand = (state == S_ADV_Y) ? cur_imag[limb_k] : cur_real[limb_k];
    assign adv_sum     = {1'b0, adv_operand} + {1'b0, step_mem[limb_k]}
                       + (LIMB_SIZE_BITS + 1)'(carry);

    // State register: synchronous reset aborts any job and returns to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each packet word advances on its own handshake; after
    // the end-of-stream word the walk decides between next column, next row,
    // or finishing the tile. The adder phases last exactly num_limbs cycles.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (cfg_fire && cfg_last) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (out_fire) begin
                    state_next = S_LIMBS;
                end
            end
            S_LIMBS: begin
                if (out_fire) begin
                    state_next = S_REAL;
                end
            end
            S_REAL: begin
                if (out_fire && last_limb) begin
                    state_next = S_IMAG;
                end
            end
            S_IMAG: begin
                if (out_fire && last_limb) begin
                    state_next = S_ITER;
                end
            end
            S_ITER: begin
                if (out_fire) begin
                    if (!last_x) begin
                        state_next = S_ADV_X;
                    end else if (!last_y) begin
                        state_next = S_ADV_Y;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_ADV_X, S_ADV_Y: begin
                if (limb_k == '0) begin
                    state_next = S_ADDR;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode. Everything is forced quiet while reset is held so an
    // in-flight word cannot be taken during the abort cycle.
    always_comb begin
        out_valid         = 1'b0;
        out_data          = 32'd0;
        out_end_of_stream = 1'b0;
        cfg_ready         = !reset && (state == S_IDLE);
        tile_done         = !reset && tile_done_q;
        if (!reset) begin
            unique case (state)
                S_ADDR: begin
                    out_valid = 1'b1;
                    out_data  = {3'd0, pixel_addr};
                end
                S_LIMBS: begin
                    out_valid = 1'b1;
                    out_data  = {3'd1, 29'(num_limbs)};
                end
                S_REAL: begin
                    out_valid = 1'b1;
                    out_data  = {3'd2, 29'(cur_real[limb_k])};
                end
                S_IMAG: begin
                    out_valid = 1'b1;
                    out_data  = {3'd3, 29'(cur_imag[limb_k])};
                end
                S_ITER: begin
                    out_valid         = 1'b1;
                    out_data          = {3'd4, 13'd0, iter_lim};
                    out_end_of_stream = 1'b1;
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    // Job registers, pixel coordinates and the limb sequencer. The limb index
    // counts up while emitting limbs and down while adding, so the adder sees
    // the least significant limb first and the carry ripples upward.
    always_ff @(posedge clock) begin
        if (reset) begin
            base_addr   <= '0;
            num_limbs   <= LIMB_INDEX_BITS'(1);
            iter_lim    <= '0;
            real_wr_idx <= '0;
            imag_wr_idx <= '0;
            step_wr_idx <= '0;
            x           <= '0;
            y           <= '0;
            limb_k      <= '0;
            carry       <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            tile_done_q <= 1'b0;
            if (cfg_fire) begin
                case (cfg_type)
                    3'd0: base_addr <= cfg_data[28:0];
                    3'd1: begin
                        if (cfg_data[LIMB_INDEX_BITS-1:0] == '0) begin
                            num_limbs <= LIMB_INDEX_BITS'(1);
                        end else begin
                            num_limbs <= cfg_data[LIMB_INDEX_BITS-1:0];
                        end
                    end
                    3'd2: real_wr_idx <= real_wr_idx + LIMB_INDEX_BITS'(1);
                    3'd3: imag_wr_idx <= imag_wr_idx + LIMB_INDEX_BITS'(1);
                    3'd4: iter_lim <= cfg_data[15:0];
                    3'd5: step_wr_idx <= step_wr_idx + LIMB_INDEX_BITS'(1);
                    default: begin
                    end
                endcase
                if (cfg_last) begin
                    real_wr_idx <= '0;
                    imag_wr_idx <= '0;
                    step_wr_idx <= '0;
                    x           <= '0;
                    y           <= '0;
                end
            end
            case (state)
                S_LIMBS: begin
                    if (out_fire) begin
                        limb_k <= '0;
                    end
                end
                S_REAL, S_IMAG: begin
                    if (out_fire) begin
                        limb_k <= last_limb ? '0 : limb_k + LIMB_INDEX_BITS'(1);
                    end
                end
                S_ITER: begin
                    if (out_fire) begin
                        limb_k <= last_limb_idx;
                        carry  <= 1'b0;
                        if (last_x && last_y) begin
                            tile_done_q <= 1'b1;
                        end
                    end
                end
                S_ADV_X, S_ADV_Y: begin
                    carry  <= adv_sum[LIMB_SIZE_BITS];
                    limb_k <= limb_k - LIMB_INDEX_BITS'(1);
                    if (limb_k == '0) begin
                        if (state == S_ADV_X) begin
                            x <= x + TILE_BITS'(1);
                        end else begin
                            x <= '0;
                            y <= y + TILE_BITS'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Limb arrays are plain storage with no reset. Config writes only happen
    // while idle and adder writes only during ADV, so they never collide.
    // Starting a new row reloads the real part from its saved start value.
    always_ff @(posedge clock) begin
        if (cfg_fire) begin
            case (cfg_type)
                3'd2: begin
                    start_real[real_wr_idx] <= cfg_limb;
                    cur_real[real_wr_idx]   <= cfg_limb;
                end
                3'd3: cur_imag[imag_wr_idx] <= cfg_limb;
                3'd5: step_mem[step_wr_idx] <= cfg_limb;
                default: begin
                end
            endcase
        end
        if (!reset && state == S_ADV_X) begin
            cur_real[limb_k] <= adv_sum[LIMB_SIZE_BITS-1:0];
        end
        if (!reset && state == S_ADV_Y) begin
            cur_real[limb_k] <= start_real[limb_k];
            cur_imag[limb_k] <= adv_sum[LIMB_SIZE_BITS-1:0];
        end
    end

endmodule

// File: tb/tb_tile_packet_generator.sv
// ---------------------------------------------------------------------------
// tb_tile_packet_generator
//
// Bench for tile_packet_generator with a 2x2 tile. A job-level model turns
// each accepted configuration into the full list of expected packet words
// using wide-integer arithmetic on the complex coordinate; a negedge monitor
// compares every presented word, handshake stability, the adder gap,
// cfg_ready and tile_done against it. Directed jobs pin known literal words.
// ---------------------------------------------------------------------------
module tb_tile_packet_generator;

    localparam int LIB   = 6;
    localparam int LSB   = 27;
    localparam int TBITS = 1;
    localparam int SIDE  = 2 ** TBITS;
    localparam int NPIX  = SIDE * SIDE;

    logic        clock;
    logic        reset;
    logic [31:0] cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_last;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_end_of_stream;
    logic        tile_done;

    tile_packet_generator #(
        .LIMB_INDEX_BITS(LIB),
        .LIMB_SIZE_BITS (LSB),
        .TILE_BITS      (TBITS)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cfg_data         (cfg_data),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_last         (cfg_last),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_end_of_stream(out_end_of_stream),
        .tile_done        (tile_done)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    // Job-level model of the configuration registers.
    logic [28:0]    m_base;
    int             m_n;
    logic [15:0]    m_iter;
    logic [LSB-1:0] m_real [64];
    logic [LSB-1:0] m_imag [64];
    logic [LSB-1:0] m_step [64];
    int             m_ri;
    int             m_ii;
    int             m_si;

    logic [32:0]    exp_q [$];
    logic [31:0]    seen [$];
    int             job_n = 1;
    bit             job_active = 1'b0;
    int             done_pulses = 0;

    logic [LSB-1:0] jr [4];
    logic [LSB-1:0] ji [4];
    logic [LSB-1:0] js [4];

    int             ready_mode = 0;
    int             hold_low = 0;

    // Monitor bookkeeping.
    bit             prev_valid = 1'b0;
    bit             prev_ready = 1'b0;
    logic [31:0]    prev_data = 32'd0;
    bit             in_gap = 1'b0;
    int             gap_cnt = 0;
    bit             done_next = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout required event", name);
    endtask

    task automatic modelReset();
        m_base = '0;
        m_n    = 1;
        m_iter = '0;
        m_ri   = 0;
        m_ii   = 0;
        m_si   = 0;
    endtask

    // Expand the current model job into every packet word of the tile.
    task automatic buildExpected();
        logic [127:0] mask;
        logic [127:0] r0;
        logic [127:0] i0;
        logic [127:0] st;
        logic [127:0] rv;
        logic [127:0] iv;
        logic [127:0] sh;
        logic [28:0]  addr;
        mask = (128'd1 << (m_n * LSB)) - 128'd1;
        r0 = '0;
        i0 = '0;
        st = '0;
        for (int k = 0; k < m_n; k++) begin
            r0 = (r0 << LSB) | 128'(m_real[k]);
            i0 = (i0 << LSB) | 128'(m_imag[k]);
            st = (st << LSB) | 128'(m_step[k]);
        end
        for (int p = 0; p < NPIX; p++) begin
            rv   = (r0 + 128'(p % SIDE) * st) & mask;
            iv   = (i0 + 128'(p / SIDE) * st) & mask;
            addr = m_base + 29'(p);
            exp_q.push_back({1'b0, 3'd0, addr});
            exp_q.push_back({1'b0, 3'd1, 23'd0, 6'(m_n)});
            for (int k = 0; k < m_n; k++) begin
                sh = rv >> ((m_n - 1 - k) * LSB);
                exp_q.push_back({1'b0, 3'd2, 2'b00, sh[LSB-1:0]});
            end
            for (int k = 0; k < m_n; k++) begin
                sh = iv >> ((m_n - 1 - k) * LSB);
                exp_q.push_back({1'b0, 3'd3, 2'b00, sh[LSB-1:0]});
            end
            exp_q.push_back({1'b1, 3'd4, 13'd0, m_iter});
        end
        job_n = m_n;
    endtask

    // Send one config word; call in the posedge+1 phase.
    task automatic applyStimulus(input logic [2:0] t, input logic [28:0] p, input bit last);
        int w;
        cfg_data  = {t, p};
        cfg_valid = 1'b1;
        cfg_last  = last;
        w = 0;
        @(negedge clock);
        while (!cfg_ready && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (!cfg_ready) begin
            reportTimeout("cfg_accept");
        end else begin
            @(posedge clock);
            case (t)
                3'd0: m_base = p;
                3'd1: m_n = (p[5:0] == 6'd0) ? 1 : int'(p[5:0]);
                3'd2: begin m_real[m_ri] = p[LSB-1:0]; m_ri = (m_ri + 1) % 64; end
                3'd3: begin m_imag[m_ii] = p[LSB-1:0]; m_ii = (m_ii + 1) % 64; end
                3'd4: m_iter = p[15:0];
                3'd5: begin m_step[m_si] = p[LSB-1:0]; m_si = (m_si + 1) % 64; end
                default: begin end
            endcase
            if (last) begin
                m_ri = 0;
                m_ii = 0;
                m_si = 0;
                buildExpected();
                job_active = 1'b1;
            end
        end
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = 32'd0;
    endtask

    task automatic runJob(input logic [28:0] base, input logic [28:0] ncfg, input int n,
                          input logic [15:0] iter, input bit junk);
        @(posedge clock);
        #1;
        seen.delete();
        applyStimulus(3'd0, base, 1'b0);
        applyStimulus(3'd1, ncfg, 1'b0);
        for (int k = 0; k < n; k++) applyStimulus(3'd2, {2'($urandom), jr[k]}, 1'b0);
        for (int k = 0; k < n; k++) applyStimulus(3'd3, {2'($urandom), ji[k]}, 1'b0);
        for (int k = 0; k < n; k++) applyStimulus(3'd5, {2'($urandom), js[k]}, 1'b0);
        if (junk) begin
            applyStimulus(3'd6, 29'($urandom), 1'b0);
            applyStimulus(3'd7, 29'($urandom), 1'b0);
        end
        applyStimulus(3'd4, {13'h1ABC, iter}, 1'b1);
    endtask

    task automatic waitJobDone();
        int c;
        c = 0;
        while (job_active && c < 4000) begin
            @(posedge clock);
            c++;
        end
        if (job_active) reportTimeout("job_done");
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Drive out_ready shortly after each rising edge.
    always @(posedge clock) begin
        #1;
        if (hold_low > 0) begin
            out_ready = 1'b0;
            hold_low--;
        end else begin
            case (ready_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clock) begin
        if (!reset && tile_done) done_pulses++;
    end

    // Compare process: checks the DUT against the model every cycle.
    always @(negedge clock) begin
        logic [32:0] e;
        if (reset) begin
            checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
            checkOutput("rst_out_data", out_data, 32'd0);
            checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
            checkOutput("rst_tile_done", {31'd0, tile_done}, 32'd0);
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            in_gap     = 1'b0;
            done_next  = 1'b0;
        end else begin
            checkOutput("tile_done", {31'd0, tile_done}, {31'd0, done_next});
            done_next = 1'b0;
            checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, !job_active});
            if (prev_valid && !prev_ready) begin
                checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stall_data", out_data, prev_data);
            end
            if (in_gap) begin
                if (!out_valid) begin
                    gap_cnt++;
                    if (gap_cnt > job_n + 8) begin
                        reportTimeout("adv_gap");
                        in_gap = 1'b0;
                    end
                end else begin
                    checkOutput("adv_gap", gap_cnt, job_n);
                    in_gap = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", out_data, 32'd0);
                    if (out_data == 32'd0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_word: got valid required idle");
                    end
                end else begin
                    e = exp_q[0];
                    checkOutput("out_data", out_data, e[31:0]);
                    checkOutput("out_eos", {31'd0, out_end_of_stream}, {31'd0, e[32]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen.push_back(out_data);
                        if (e[32]) begin
                            if (exp_q.size() == 0) begin
                                done_next  = 1'b1;
                                job_active = 1'b0;
                            end else begin
                                in_gap  = 1'b1;
                                gap_cnt = 0;
                            end
                        end
                    end
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        int d0;
        int w;
        int n;
        reset     = 1'b1;
        cfg_data  = 32'd0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        out_ready = 1'b1;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        checkOutput("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        checkOutput("reset_tile_done", {31'd0, tile_done}, 32'd0);

        // Basic 2x2 walk with one limb.
        $display("[TB] job 1: basic walk");
        jr[0] = 27'h10; ji[0] = 27'h20; js[0] = 27'h2;
        d0 = done_pulses;
        runJob(29'h100, 29'd1, 1, 16'd500, 1'b0);
        waitJobDone();
        checkOutput("t1_words", seen.size(), 32'd20);
        if (seen.size() == 20) begin
            checkOutput("t1_addr0", seen[0], 32'h00000100);
            checkOutput("t1_limbs", seen[1], 32'h20000001);
            checkOutput("t1_real0", seen[2], 32'h40000010);
            checkOutput("t1_imag0", seen[3], 32'h60000020);
            checkOutput("t1_iter", seen[4], 32'h800001F4);
            checkOutput("t1_addr1", seen[5], 32'h00000101);
            checkOutput("t1_real1", seen[7], 32'h40000012);
            checkOutput("t1_imag1", seen[8], 32'h60000020);
            checkOutput("t1_addr2", seen[10], 32'h00000102);
            checkOutput("t1_real2", seen[12], 32'h40000010);
            checkOutput("t1_imag2", seen[13], 32'h60000022);
            checkOutput("t1_addr3", seen[15], 32'h00000103);
            checkOutput("t1_real3", seen[17], 32'h40000012);
            checkOutput("t1_imag3", seen[18], 32'h60000022);
        end
        checkOutput("t1_done_pulses", done_pulses - d0, 32'd1);

        // Carry across limbs.
        $display("[TB] job 2: carry");
        jr[0] = 27'h0; jr[1] = 27'h7FFFFFF; ji[0] = 27'h5; ji[1] = 27'h6;
        js[0] = 27'h0; js[1] = 27'h1;
        runJob(29'h2000, 29'd2, 2, 16'd7, 1'b0);
        waitJobDone();
        if (seen.size() == 28) begin
            checkOutput("t2_real_hi", seen[9], 32'h40000001);
            checkOutput("t2_real_lo", seen[10], 32'h40000000);
        end else begin
            checkOutput("t2_words", seen.size(), 32'd28);
        end

        // Wrap of the most significant limb.
        $display("[TB] job 3: wrap");
        jr[0] = 27'h7FFFFFF; jr[1] = 27'h7FFFFFF;
        runJob(29'h1FFFFFFE, 29'd2, 2, 16'd9, 1'b0);
        waitJobDone();
        if (seen.size() == 28) begin
            checkOutput("t3_real_hi", seen[9], 32'h40000000);
            checkOutput("t3_real_lo", seen[10], 32'h40000000);
        end else begin
            checkOutput("t3_words", seen.size(), 32'd28);
        end

        // Toggling backpressure plus a 7-cycle stall mid-packet.
        $display("[TB] job 4: backpressure");
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            jr[k] = 27'($urandom); ji[k] = 27'($urandom); js[k] = 27'($urandom);
        end
        runJob(29'h345, 29'd3, 3, 16'hBEEF, 1'b0);
        w = 0;
        while (seen.size() < 12 && w < 2000) begin
            @(posedge clock);
            w++;
        end
        hold_low = 7;
        waitJobDone();
        checkOutput("t4_words", seen.size(), 32'd36);
        ready_mode = 0;

        // Zero limb count and ignored config types.
        $display("[TB] job 5: zero limbs and junk types");
        jr[0] = 27'h123; ji[0] = 27'h456; js[0] = 27'h7;
        runJob(29'h77, 29'h00004000, 1, 16'd3, 1'b1);
        waitJobDone();
        checkOutput("t5_words", seen.size(), 32'd20);
        if (seen.size() == 20) checkOutput("t5_limbs", seen[1], 32'h20000001);

        // Reset during the third packet's real limbs.
        $display("[TB] job 6: reset mid-job");
        ready_mode = 1;
        jr[0] = 27'h1; jr[1] = 27'h2; ji[0] = 27'h3; ji[1] = 27'h4;
        js[0] = 27'h5; js[1] = 27'h6;
        runJob(29'h500, 29'd2, 2, 16'd11, 1'b0);
        w = 0;
        while (seen.size() < 16 && w < 2000) begin
            @(posedge clock);
            w++;
        end
        if (seen.size() < 16) reportTimeout("t6_reach_pkt3");
        #1;
        reset = 1'b1;
        exp_q.delete();
        job_active = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        checkOutput("t6_tile_done", {31'd0, tile_done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            jr[k] = 27'($urandom); ji[k] = 27'($urandom); js[k] = 27'($urandom);
        end
        runJob(29'h900, 29'd3, 3, 16'd21, 1'b0);
        waitJobDone();
        checkOutput("t6_words", seen.size(), 32'd36);
        if (seen.size() > 0) checkOutput("t6_first_addr", seen[0], 32'h00000900);

        // Randomised jobs.
        for (int j = 0; j < 6; j++) begin
            $display("[TB] random job %0d", j);
            n = $urandom_range(1, 4);
            ready_mode = $urandom_range(0, 1);
            for (int k = 0; k < 4; k++) begin
                jr[k] = 27'($urandom); ji[k] = 27'($urandom); js[k] = 27'($urandom);
            end
            if ($urandom_range(0, 1) == 1) jr[n-1] = 27'h7FFFFFF;
            d0 = done_pulses;
            runJob(29'($urandom), {23'($urandom), 6'(n)}, n, 16'($urandom),
                   1'($urandom_range(0, 1)));
            waitJobDone();
            checkOutput("rand_words", seen.size(), 4 * (2 * n + 3));
            checkOutput("rand_done_pulses", done_pulses - d0, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
